// File: rtl/uart_cmd_handler_pkg.sv
// rtl/uart_cmd_handler_pkg.sv - opcodes, reply codes, register indices and state encodings
package uart_cmd_handler_pkg;

  localparam logic [7:0] CMD_DELAY   = 8'h64;
  localparam logic [7:0] CMD_WIDTH   = 8'h77;
  localparam logic [7:0] CMD_COUNT   = 8'h6E;
  localparam logic [7:0] CMD_SPACING = 8'h73;
  localparam logic [7:0] CMD_ARM     = 8'h67;
  localparam logic [7:0] CMD_READ    = 8'h72;

  localparam logic [7:0] ACK_DEFAULT = 8'h06;
  localparam logic [7:0] NAK_DEFAULT = 8'h15;

  localparam logic [1:0] IDX_DELAY   = 2'd0;
  localparam logic [1:0] IDX_WIDTH   = 2'd1;
  localparam logic [1:0] IDX_COUNT   = 2'd2;
  localparam logic [1:0] IDX_SPACING = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PAYLOAD, ST_INDEX, ST_COMMIT, ST_TX_LOAD, ST_TX_WAIT
  } state_t;

  typedef enum logic [1:0] {
    Q_IDLE, Q_LOAD, Q_SKIP, Q_WAIT
  } q_state_t;

  function automatic int field_bytes(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_cmd_handler_if.sv
// rtl/uart_cmd_handler_if.sv - byte stream between uart_rx/uart_tx and the command handler
interface uart_cmd_handler_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] tx_data_o;
  logic       tx_en_o;
  logic       tx_busy_i;

  modport master (output rx_data_i, rx_valid_i, tx_busy_i, input tx_data_o, tx_en_o);
  modport slave  (input rx_data_i, rx_valid_i, tx_busy_i, output tx_data_o, tx_en_o);
endinterface

// File: rtl/uart_cmd_handler_reply.sv
// rtl/uart_cmd_handler_reply.sv - up to 4-byte reply buffer sent LSB first through uart_tx
module uart_reply_queue
  import uart_cmd_handler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic [2:0]  push_cnt,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        wait_done,
  output logic        more
);
  q_state_t    state, state_nxt;
  logic [31:0] buf_q;
  logic [2:0]  cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= Q_IDLE;
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (push && state == Q_IDLE) begin
        buf_q <= push_data;
        cnt_q <= push_cnt;
      end else if (tx_en) begin
        buf_q <= {8'h00, buf_q[31:8]};
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  // Q_SKIP covers the cycle before uart_tx raises busy in response to tx_en
  always_comb begin
    state_nxt = state;
    tx_en     = 1'b0;
    tx_data   = 8'h00;
    wait_done = 1'b0;
    case (state)
      Q_IDLE: if (push) state_nxt = Q_LOAD;
      Q_LOAD: begin
        if (!tx_busy) begin
          tx_en     = 1'b1;
          tx_data   = buf_q[7:0];
          state_nxt = Q_SKIP;
        end
      end
      Q_SKIP: state_nxt = Q_WAIT;
      Q_WAIT: begin
        if (!tx_busy) begin
          wait_done = 1'b1;
          state_nxt = (cnt_q != 3'd0) ? Q_LOAD : Q_IDLE;
        end
      end
      default: state_nxt = Q_IDLE;
    endcase
  end

  assign more = (cnt_q != 3'd0);

endmodule

// File: rtl/uart_cmd_handler.sv
// rtl/uart_cmd_handler.sv - binary command parser updating glitch timing registers with ACK/NAK replies
module uart_cmd_handler
  import uart_cmd_handler_pkg::*;
#(
  parameter int         DELAY_W        = 16,
  parameter int         WIDTH_W        = 8,
  parameter int         COUNT_W        = 8,
  parameter int         SPACING_W      = 16,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_cmd_handler_if.slave    bus,
  output logic [DELAY_W-1:0]   delay_o,
  output logic [WIDTH_W-1:0]   width_o,
  output logic [COUNT_W-1:0]   num_pulses_o,
  output logic [SPACING_W-1:0] pulse_spacing_o,
  output logic                 pulse_en_o,
  output logic                 cmd_busy_o
);
  localparam int N_DELAY   = field_bytes(DELAY_W);
  localparam int N_WIDTH   = field_bytes(WIDTH_W);
  localparam int N_COUNT   = field_bytes(COUNT_W);
  localparam int N_SPACING = field_bytes(SPACING_W);
  localparam int N_MAX     = max_int(max_int(N_DELAY, N_WIDTH), max_int(N_COUNT, N_SPACING));
  localparam int SH_W      = 8 * N_MAX;
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [7:0]      cmd_q;
  logic [SH_W-1:0] shadow_q;
  logic [2:0]      bcnt_q;
  logic [TO_W-1:0] tcnt_q;
  logic            timeout;
  logic [2:0]      n_sel;
  logic [31:0]     read_val;
  logic [2:0]      read_cnt;
  logic            push;
  logic [31:0]     push_data;
  logic [2:0]      push_cnt;
  logic            q_wait_done;
  logic            q_more;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      cmd_q           <= '0;
      shadow_q        <= '0;
      bcnt_q          <= '0;
      tcnt_q          <= '0;
      delay_o         <= '0;
      width_o         <= '0;
      num_pulses_o    <= '0;
      pulse_spacing_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && bus.rx_valid_i) begin
        cmd_q    <= bus.rx_data_i;
        shadow_q <= '0;
        bcnt_q   <= '0;
      end else if (state == ST_PAYLOAD && bus.rx_valid_i) begin
        shadow_q <= shadow_q | (SH_W'(bus.rx_data_i) << {bcnt_q, 3'b000});
        bcnt_q   <= bcnt_q + 3'd1;
      end
      if ((state == ST_PAYLOAD || state == ST_INDEX) && !bus.rx_valid_i && !timeout)
        tcnt_q <= tcnt_q + TO_W'(1);
      else
        tcnt_q <= '0;
      // Only the addressed register moves; shadow bits above its width are dropped
      if (state == ST_COMMIT) begin
        case (cmd_q)
          CMD_DELAY:   delay_o         <= shadow_q[DELAY_W-1:0];
          CMD_WIDTH:   width_o         <= shadow_q[WIDTH_W-1:0];
          CMD_COUNT:   num_pulses_o    <= shadow_q[COUNT_W-1:0];
          CMD_SPACING: pulse_spacing_o <= shadow_q[SPACING_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    n_sel = 3'(N_DELAY);
    case (cmd_q)
      CMD_WIDTH:   n_sel = 3'(N_WIDTH);
      CMD_COUNT:   n_sel = 3'(N_COUNT);
      CMD_SPACING: n_sel = 3'(N_SPACING);
      default: ;
    endcase
    read_val = 32'(delay_o);
    read_cnt = 3'(N_DELAY);
    case (bus.rx_data_i[1:0])
      IDX_WIDTH:   begin read_val = 32'(width_o);         read_cnt = 3'(N_WIDTH);   end
      IDX_COUNT:   begin read_val = 32'(num_pulses_o);    read_cnt = 3'(N_COUNT);   end
      IDX_SPACING: begin read_val = 32'(pulse_spacing_o); read_cnt = 3'(N_SPACING); end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = {24'h0, ACK_BYTE};
    push_cnt  = 3'd1;
    timeout   = (state == ST_PAYLOAD || state == ST_INDEX) && !bus.rx_valid_i && (tcnt_q == TO_LAST);
    case (state)
      ST_IDLE: begin
        if (bus.rx_valid_i) begin
          case (bus.rx_data_i)
            CMD_DELAY, CMD_WIDTH, CMD_COUNT, CMD_SPACING: state_nxt = ST_PAYLOAD;
            CMD_ARM:  state_nxt = ST_COMMIT;
            CMD_READ: state_nxt = ST_INDEX;
            default: begin
              push      = 1'b1;
              push_data = {24'h0, NAK_BYTE};
              state_nxt = ST_TX_LOAD;
            end
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (timeout) begin
          push      = 1'b1;
          push_data = {24'h0, NAK_BYTE};
          state_nxt = ST_TX_LOAD;
        end else if (bus.rx_valid_i && (bcnt_q + 3'd1 == n_sel)) begin
          state_nxt = ST_COMMIT;
        end
      end
      ST_INDEX: begin
        if (timeout || (bus.rx_valid_i && bus.rx_data_i > 8'd3)) begin
          push      = 1'b1;
          push_data = {24'h0, NAK_BYTE};
          state_nxt = ST_TX_LOAD;
        end else if (bus.rx_valid_i) begin
          push      = 1'b1;
          push_data = read_val;
          push_cnt  = read_cnt;
          state_nxt = ST_TX_LOAD;
        end
      end
      ST_COMMIT: begin
        push      = 1'b1;
        state_nxt = ST_TX_LOAD;
      end
      ST_TX_LOAD: if (bus.tx_en_o) state_nxt = ST_TX_WAIT;
      ST_TX_WAIT: if (q_wait_done) state_nxt = q_more ? ST_TX_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pulse_en_o = (state == ST_COMMIT) && (cmd_q == CMD_ARM);
  assign cmd_busy_o = (state != ST_IDLE);

  uart_reply_queue u_reply (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .push_cnt  (push_cnt),
    .tx_busy   (bus.tx_busy_i),
    .tx_data   (bus.tx_data_o),
    .tx_en     (bus.tx_en_o),
    .wait_done (q_wait_done),
    .more      (q_more)
  );

endmodule

// File: doc/uart_cmd_handler.md
Name: uart_cmd_handler

Overview:
Parametrised successor to the echo-only UART handler. Parses a binary command protocol from the uart_rx byte stream, atomically updates the glitch-timing registers, supports register read-back and an arm strobe, and replies through uart_tx with ACK/NAK/data bytes. It sits between the existing uart_rx/uart_tx pair and the pulse generator.

Parameters:
DELAY_W, 16, width of delay_o (1..32)
WIDTH_W, 8, width of width_o (1..32)
COUNT_W, 8, width of num_pulses_o (1..32)
SPACING_W, 16, width of pulse_spacing_o (1..32)
TIMEOUT_CYCLES, 50000, maximum idle clk cycles between bytes of one command (>=2)
ACK_BYTE, 8'h06, reply on successful write/arm
NAK_BYTE, 8'h15, reply on unknown command, bad index or timeout

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx_data_i  in  8  received byte from uart_rx
rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
tx_data_o  out  8  byte to uart_tx
tx_en_o  out  1  one-cycle send strobe to uart_tx
tx_busy_i  in  1  uart_tx busy; rises the cycle after tx_en_o
delay_o  out  DELAY_W  glitch delay
width_o  out  WIDTH_W  glitch width
num_pulses_o  out  COUNT_W  pulse count
pulse_spacing_o  out  SPACING_W  inter-pulse spacing
pulse_en_o  out  1  one-cycle arm strobe
cmd_busy_o  out  1  high whenever FSM not in IDLE

Behaviour:
- Reset (async, active-high): all outputs 0, FSM IDLE, shadow/byte counters 0, timeout counter 0.
- Byte count per field N = ceil(W/8); payload little-endian; bits above W discarded.
- Commands (first byte): 'd' 0x64 delay, 'w' 0x77 width, 'n' 0x6E num_pulses, 's' 0x73 spacing, 'g' 0x67 arm, 'r' 0x72 read. Others -> NAK.
- States: IDLE, PAYLOAD, INDEX, COMMIT, TX_LOAD, TX_WAIT.
- IDLE: on rx_valid_i decode; write cmd -> PAYLOAD (byte count 0, shadow cleared); 'g' -> COMMIT; 'r' -> INDEX; unknown -> TX_LOAD with NAK.
- PAYLOAD: each rx_valid_i shifts byte into shadow at position count*8; after Nth byte -> COMMIT.
- COMMIT: exactly one cycle; target register <= shadow[W-1:0] (or pulse_en_o=1 for 'g'); queue ACK; -> TX_LOAD. Register visible 2 cycles after last rx_valid_i. Other registers never disturbed; partial commands never alter outputs.
- INDEX: byte 0..3 selects delay/width/num_pulses/pulse_spacing; queue its N bytes LSB first; index >3 -> NAK.
- TX_LOAD: when tx_busy_i=0 drive tx_data_o, pulse tx_en_o one cycle -> TX_WAIT. TX_WAIT: skip one cycle (busy rise), then wait tx_busy_i=0; more queued bytes -> TX_LOAD else IDLE.
- Timeout: in PAYLOAD/INDEX a counter increments every cycle without rx_valid_i, clears on rx_valid_i; reaching TIMEOUT_CYCLES -> discard, NAK, outputs unchanged.
- rx_valid_i during TX_LOAD/TX_WAIT/COMMIT: byte dropped, no effect.
- pulse_en_o high for exactly one cycle per 'g'; 0 otherwise.
- Reset mid-command or mid-reply: immediate return to reset values, tx_en_o low.

Decomposition:
- Shared package: command opcodes, ACK/NAK defaults, state encoding, index constants.
- One sub-module natural: uart_reply_queue (up to 4-byte reply buffer + tx_en/busy handshake FSM). uart_rx/uart_tx stay external.

Test Plan:
- Defaults: 'd',0x34,0x12 -> delay_o=0x1234 two cycles after last byte, tx 0x06, other regs 0.
- Read-back: 's',0xCD,0xAB then 'r',0x03 -> tx 0x06, 0xCD, 0xAB in order, one tx_en_o per byte only while tx_busy_i low.
- Errors: 'x' -> tx 0x15; 'r',0x07 -> tx 0x15; no output change.
- Timeout: 'd',0x34 then silence TIMEOUT_CYCLES -> tx 0x15, delay_o unchanged; next 'd',0x01,0x00 -> delay_o=1.
- Arm + width param: WIDTH_W=12, 'w',0xFF,0xFF -> width_o=0xFFF; 'g' -> pulse_en_o single-cycle pulse, tx 0x06.
- Reset: assert rst after 'n' (mid-payload) and during an ACK -> all outputs 0 asynchronously, tx_en_o low; new 'n',0x05 -> num_pulses_o=5.
